// File: rtl/des_key_sched_dec_if.sv
// Handshake/data bundle between a key-schedule consumer (master) and des_key_sched_dec (slave).
// The enc signal exists only when DES_KEY_ENC_MODE_EN is defined.
interface des_key_sched_dec_if;
    logic        start;
    logic [55:0] key_cd;
    logic        next;
`ifdef DES_KEY_ENC_MODE_EN
    logic        enc;
`endif
    logic [55:0] cd_out;
    logic [3:0]  round;
    logic        subkey_valid;
    logic        busy;
    logic        ready;

`ifdef DES_KEY_ENC_MODE_EN
    modport master (output start, key_cd, next, enc,
                    input  cd_out, round, subkey_valid, busy, ready);
    modport slave  (input  start, key_cd, next, enc,
                    output cd_out, round, subkey_valid, busy, ready);
`else
    modport master (output start, key_cd, next,
                    input  cd_out, round, subkey_valid, busy, ready);
    modport slave  (input  start, key_cd, next,
                    output cd_out, round, subkey_valid, busy, ready);
`endif
endinterface

// File: rtl/des_key_sched_dec.sv
// DES key schedule sequencer: steps C||D through the 16 subkey pre-images (K16..K1) for external PC-2.
// Define DES_KEY_ENC_MODE_EN to add an enc input that runs the schedule in encryption order (K1..K16).
module des_key_sched_dec (
    input  logic               clk,
    input  logic               rst,
    des_key_sched_dec_if.slave bus
);

    typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

    state_t      r_state;
    logic [27:0] r_c;
    logic [27:0] r_d;
    logic [3:0]  r_round;
    logic        r_valid;
    logic        r_busy;
    logic        r_ready;
`ifdef DES_KEY_ENC_MODE_EN
    logic        r_enc;
`endif

    logic [1:0]  w_shift_dec;
    logic        w_last;
    logic [27:0] w_c_nxt;
    logic [27:0] w_d_nxt;
    logic [3:0]  w_round_nxt;
    logic [27:0] w_load_c;
    logic [27:0] w_load_d;
    logic [3:0]  w_load_round;

    // DES left-shift schedule: single shift for rounds 1, 2, 9, 16, double otherwise.
    function automatic logic [1:0] shift_amt(input logic [4:0] n);
        return ((n == 5'd1) || (n == 5'd2) || (n == 5'd9) || (n == 5'd16)) ? 2'd1 : 2'd2;
    endfunction

    function automatic logic [27:0] rotr28(input logic [27:0] x, input logic [1:0] s);
        return (s == 2'd1) ? {x[0], x[27:1]} : {x[1:0], x[27:2]};
    endfunction

    function automatic logic [27:0] rotl28(input logic [27:0] x, input logic [1:0] s);
        return (s == 2'd1) ? {x[26:0], x[27]} : {x[25:0], x[27:26]};
    endfunction

    // Decryption walks backwards, so undoing round n+1's shift exposes Kn's pre-image.
    assign w_shift_dec = shift_amt({1'b0, r_round} + 5'd1);

`ifdef DES_KEY_ENC_MODE_EN
    logic [1:0] w_shift_enc;
    assign w_shift_enc = shift_amt({1'b0, r_round} + 5'd2);

    always_comb begin
        w_last      = r_enc ? (r_round == 4'd15) : (r_round == 4'd0);
        w_c_nxt     = r_enc ? rotl28(r_c, w_shift_enc) : rotr28(r_c, w_shift_dec);
        w_d_nxt     = r_enc ? rotl28(r_d, w_shift_enc) : rotr28(r_d, w_shift_dec);
        w_round_nxt = r_enc ? (r_round + 4'd1) : (r_round - 4'd1);
    end

    always_comb begin
        w_load_c     = bus.enc ? rotl28(bus.key_cd[55:28], 2'd1) : bus.key_cd[55:28];
        w_load_d     = bus.enc ? rotl28(bus.key_cd[27:0], 2'd1)  : bus.key_cd[27:0];
        w_load_round = bus.enc ? 4'd0 : 4'd15;
    end
`else
    always_comb begin
        w_last      = (r_round == 4'd0);
        w_c_nxt     = rotr28(r_c, w_shift_dec);
        w_d_nxt     = rotr28(r_d, w_shift_dec);
        w_round_nxt = r_round - 4'd1;
    end

    // The key is C0||D0, which after a full 28-bit rotation is also K16's pre-image.
    always_comb begin
        w_load_c     = bus.key_cd[55:28];
        w_load_d     = bus.key_cd[27:0];
        w_load_round = 4'd15;
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_c     <= '0;
            r_d     <= '0;
            r_round <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_ready <= 1'b0;
`ifdef DES_KEY_ENC_MODE_EN
            r_enc   <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    r_ready <= 1'b0;
                    if (bus.start) begin
                        r_c     <= w_load_c;
                        r_d     <= w_load_d;
                        r_round <= w_load_round;
                        r_valid <= 1'b1;
                        r_busy  <= 1'b1;
                        r_state <= ROUND;
`ifdef DES_KEY_ENC_MODE_EN
                        r_enc   <= bus.enc;
`endif
                    end
                end
                ROUND: begin
                    if (bus.next) begin
                        if (w_last) begin
                            r_valid <= 1'b0;
                            r_ready <= 1'b1;
                            r_state <= DONE;
                        end else begin
                            r_c     <= w_c_nxt;
                            r_d     <= w_d_nxt;
                            r_round <= w_round_nxt;
                        end
                    end
                end
                DONE: begin
                    r_ready <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                    r_ready <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.cd_out       = {r_c, r_d};
    assign bus.round        = r_round;
    assign bus.subkey_valid = r_valid;
    assign bus.busy         = r_busy;
    assign bus.ready        = r_ready;

endmodule

// File: tb/tb_des_key_sched_dec.sv
// Directed, scoreboard-checked bench for des_key_sched_dec; expected C||D values come from the
// cumulative DES shift table applied to the loaded key.
module tb_des_key_sched_dec;

    typedef struct packed {
        logic        valid;
        logic        busy;
        logic        ready;
        logic [3:0]  round;
        logic [55:0] cd;
    } exp_t;

    logic clk;
    logic rst;
    exp_t sb[$];
    int   n_assert;
    int   n_fail;

    localparam logic [55:0] KEY = {28'h0000001, 28'h8000000};

    // Total left shift from C0||D0 to the pre-image of K1..K16.
    int cum[16] = '{1, 2, 4, 6, 8, 10, 12, 14, 15, 17, 19, 21, 23, 25, 27, 28};

    des_key_sched_dec_if bus_if ();

    des_key_sched_dec dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [27:0] rot_half(input logic [27:0] x, input int k);
        logic [27:0] r;
        r = (x << k) | (x >> (28 - k));
        return r;
    endfunction

    // Pre-image of subkey K(r+1) for the given key.
    function automatic logic [55:0] pre_image(input logic [55:0] key, input int r);
        return {rot_half(key[55:28], cum[r]), rot_half(key[27:0], cum[r])};
    endfunction

    task automatic push(input logic v, input logic b, input logic rd, input int rnd, input logic [55:0] cd);
        exp_t e;
        e.valid = v;
        e.busy  = b;
        e.ready = rd;
        e.round = rnd[3:0];
        e.cd    = cd;
        sb.push_back(e);
    endtask

    task automatic check(input string tag);
        exp_t obs;
        exp_t exp;
        obs = {bus_if.subkey_valid, bus_if.busy, bus_if.ready, bus_if.round, bus_if.cd_out};
        n_assert++;
        if (sb.size() == 0) begin
            n_fail++;
            $error("FAIL %s scoreboard empty obs=%h", tag, obs);
        end else begin
            exp = sb.pop_front();
            assert (obs === exp) else begin
                n_fail++;
                $error("FAIL %s obs v=%b b=%b r=%b rnd=%0d cd=%h exp v=%b b=%b r=%b rnd=%0d cd=%h",
                       tag, obs.valid, obs.busy, obs.ready, obs.round, obs.cd,
                       exp.valid, exp.busy, exp.ready, exp.round, exp.cd);
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        rst           = 1'b1;
        bus_if.start  = 1'b0;
        bus_if.next   = 1'b0;
        bus_if.key_cd = '0;
`ifdef DES_KEY_ENC_MODE_EN
        bus_if.enc    = 1'b0;
`endif
        #1 rst = 1'b0;
        #1;
        push(0, 0, 0, 0, '0);
        check("reset_state");

        // Start on the first edge after reset release.
        #1 rst = 1'b1;
        bus_if.start  = 1'b1;
        bus_if.key_cd = KEY;
        push(1, 1, 0, 15, KEY);
        cycle();
        check("load_k16");
        bus_if.start = 1'b0;

        // Sixteen back-to-back nexts.
        bus_if.next = 1'b1;
        push(1, 1, 0, 14, {28'h8000000, 28'h4000000});
        cycle();
        check("rot_r14");
        push(1, 1, 0, 13, {28'h2000000, 28'h1000000});
        cycle();
        check("rot_r13");
        for (int r = 12; r >= 0; r--) begin
            push(1, 1, 0, r, pre_image(KEY, r));
            cycle();
            check($sformatf("rot_r%0d", r));
        end
        push(0, 1, 1, 0, {28'h0000002, 28'h0000001});
        cycle();
        check("done_ready");
        bus_if.next = 1'b0;
        push(0, 0, 0, 0, {28'h0000002, 28'h0000001});
        cycle();
        check("idle_after_done");

        // Stall at round 7 with start pokes while busy.
        bus_if.start = 1'b1;
        push(1, 1, 0, 15, KEY);
        cycle();
        check("restart");
        bus_if.start = 1'b0;
        bus_if.next  = 1'b1;
        for (int r = 14; r >= 7; r--) begin
            push(1, 1, 0, r, pre_image(KEY, r));
            cycle();
            check($sformatf("walk_r%0d", r));
        end
        bus_if.next = 1'b0;
        for (int i = 0; i < 10; i++) begin
            bus_if.start  = (i % 3 == 0);
            bus_if.key_cd = 56'hFFFF_FFFF_FFFF_FF;
            push(1, 1, 0, 7, pre_image(KEY, 7));
            cycle();
            check($sformatf("hold_%0d", i));
        end
        bus_if.start = 1'b0;
        bus_if.next  = 1'b1;
        for (int r = 6; r >= 0; r--) begin
            push(1, 1, 0, r, pre_image(KEY, r));
            cycle();
            check($sformatf("resume_r%0d", r));
        end
        push(0, 1, 1, 0, pre_image(KEY, 0));
        cycle();
        check("done_after_stall");
        bus_if.next = 1'b0;
        cycle();
        push(0, 0, 0, 0, pre_image(KEY, 0));
        check("idle_after_stall");

        // start and next together in IDLE.
        bus_if.key_cd = KEY;
        bus_if.start  = 1'b1;
        bus_if.next   = 1'b1;
        push(1, 1, 0, 15, KEY);
        cycle();
        check("start_with_next");
        bus_if.start = 1'b0;
        bus_if.next  = 1'b0;
        push(1, 1, 0, 15, KEY);
        cycle();
        check("no_rotation");

        // Reset mid-schedule at round 9.
        bus_if.next = 1'b1;
        for (int r = 14; r >= 9; r--) begin
            push(1, 1, 0, r, pre_image(KEY, r));
            cycle();
            check($sformatf("pre_rst_r%0d", r));
        end
        bus_if.next = 1'b0;
        #2 rst = 1'b0;
        #1;
        push(0, 0, 0, 0, '0);
        check("async_reset");
        cycle();
        push(0, 0, 0, 0, '0);
        check("reset_no_ready");
        rst          = 1'b1;
        bus_if.start = 1'b1;
        push(1, 1, 0, 15, KEY);
        cycle();
        check("start_after_reset");
        bus_if.start = 1'b0;
        bus_if.next  = 1'b1;
        for (int r = 14; r >= 0; r--) begin
            push(1, 1, 0, r, pre_image(KEY, r));
            cycle();
        end
        for (int r = 14; r >= 0; r--) begin
            if (sb.size() > 1) void'(sb.pop_front());
        end
        check("post_reset_r0");
        push(0, 1, 1, 0, pre_image(KEY, 0));
        cycle();
        check("post_reset_done");
        bus_if.next = 1'b0;
        cycle();
        push(0, 0, 0, 0, pre_image(KEY, 0));
        check("post_reset_idle");

`ifdef DES_KEY_ENC_MODE_EN
        // Encryption order: K1 first, ends on the original key.
        bus_if.enc   = 1'b1;
        bus_if.start = 1'b1;
        push(1, 1, 0, 0, {28'h0000002, 28'h0000001});
        cycle();
        check("enc_load_k1");
        bus_if.start = 1'b0;
        bus_if.enc   = 1'b0;
        bus_if.next  = 1'b1;
        for (int r = 1; r <= 15; r++) begin
            push(1, 1, 0, r, pre_image(KEY, r));
            cycle();
            check($sformatf("enc_r%0d", r));
        end
        push(0, 1, 1, 15, KEY);
        cycle();
        check("enc_done");
        bus_if.next = 1'b0;
        cycle();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
